// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// Latency: n/a (declarations and a pure combinational helper).
// Backpressure: n/a.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_FUNCT = 3'd4
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  // Registered Moore controls. 'fetch' and 'pc_write' are raw and get
  // combined with MemReady / reset / Zero at the top level.
  typedef struct packed {
    alu_op_t    alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic       iord;
    logic       fetch;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       imm_zext;
  } moore_t;

  // Per-state control word. Opcode is stable in IR for the whole
  // instruction, so opcode-dependent fields can be fixed on state entry.
  function automatic moore_t moore_decode(state_t s, logic [5:0] op);
    moore_t m;
    m = '0;
    m.alu_op = ALU_AND;  // idle states present an all-zero ALUControl
    case (s)
      S_FETCH: begin
        m.src_b = 2'b01; m.alu_op = ALU_ADD; m.fetch = 1'b1;
      end
      S_DECODE: begin
        m.src_b = 2'b11; m.alu_op = ALU_ADD;
      end
      S_MEMADR: begin
        m.src_a = 1'b1; m.src_b = 2'b10; m.alu_op = ALU_ADD;
      end
      S_MEMRD:  m.iord = 1'b1;
      S_MEMWB: begin
        m.mem_to_reg = 1'b1; m.reg_write = 1'b1;
      end
      S_MEMWR: begin
        m.iord = 1'b1; m.mem_write = 1'b1;
      end
      S_RTEX: begin
        m.src_a = 1'b1; m.alu_op = ALU_FUNCT;
      end
      S_RTWB: begin
        m.reg_dst = 1'b1; m.reg_write = 1'b1;
      end
      S_BRANCH: begin
        m.src_a = 1'b1; m.alu_op = ALU_SUB; m.pc_src = 2'b01;
        m.branch = 1'b1; m.branch_ne = (op == OP_BNE);
      end
      S_IMMEX: begin
        m.src_a = 1'b1; m.src_b = 2'b10;
        case (op)
          OP_ANDI: begin m.alu_op = ALU_AND; m.imm_zext = 1'b1; end
          OP_ORI:  begin m.alu_op = ALU_OR;  m.imm_zext = 1'b1; end
          default: m.alu_op = ALU_ADD;
        endcase
      end
      S_IMMWB: begin
        m.reg_write = 1'b1;
        m.imm_zext  = (op == OP_ANDI) || (op == OP_ORI);
      end
      S_JUMP: begin
        m.pc_src = 2'b10; m.pc_write = 1'b1;
      end
      default: ;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_v2_alu_ctrl.sv
// ALU control decode: internal ALUOp plus Funct to ALUControl code.
// Latency: combinational, same cycle.
// Backpressure: none.
module alu_ctrl_decode
  import multicycle_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  alu_op_t              alu_op,
  input  logic [5:0]           funct,
  output logic [ALUCTRL_W-1:0] alu_control
);

  logic [2:0] code;

  // Map ALUOp (and Funct for R-type) onto the 3-bit ALU code.
  always_comb begin
    code = ALUC_ADD;
    case (alu_op)
      ALU_ADD: code = ALUC_ADD;
      ALU_SUB: code = ALUC_SUB;
      ALU_AND: code = ALUC_AND;
      ALU_OR:  code = ALUC_OR;
      ALU_FUNCT: begin
        case (funct)
          FN_ADD:  code = ALUC_ADD;
          FN_SUB:  code = ALUC_SUB;
          FN_AND:  code = ALUC_AND;
          FN_OR:   code = ALUC_OR;
          FN_SLT:  code = ALUC_SLT;
          default: code = ALUC_ADD;  // unknown funct silently adds
        endcase
      end
      default: code = ALUC_ADD;
    endcase
  end

  // Zero-pad to the configured output width.
  always_comb begin
    alu_control      = '0;
    alu_control[2:0] = code;
  end

endmodule

// File: rtl/multicycle_ctrl_fsm_v2.sv
// Multicycle MIPS control: Moore main FSM, ALU decode, PC-enable combine.
// Latency: lw 5, sw/R/I-arith 4, beq/bne/j 3 cycles from first FETCH.
// Backpressure: MemReady low stalls FETCH, MEMRD and MEMWR one cycle each.
module multicycle_ctrl_fsm_v2
  import multicycle_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W   = 3,
  parameter int EN_BNE      = 1,
  parameter int EN_JUMP     = 1,
  parameter int EN_MEM_WAIT = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [5:0]           OpCode,
  input  logic [5:0]           Funct,
  input  logic                 Zero,
  input  logic                 MemReady,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 IorD,
  output logic                 IRWrite,
  output logic                 MemWrite,
  output logic                 MemToReg,
  output logic                 RegDst,
  output logic                 RegWrite,
  output logic [1:0]           PCSrc,
  output logic                 PCEn,
  output logic                 ImmZext,
  output logic                 IllegalOp,
  output logic [3:0]           StateDbg
);

  state_t state, nxt;
  moore_t mo;
  logic   mem_rdy;
  logic   illegal;
  logic   pc_write;

  assign mem_rdy = MemReady | (EN_MEM_WAIT == 0);

  // Next-state logic and DECODE-time illegal opcode detection.
  always_comb begin
    nxt     = state;
    illegal = 1'b0;
    case (state)
      S_FETCH:  if (mem_rdy) nxt = S_DECODE;
      S_DECODE: begin
        case (OpCode)
          OP_LW, OP_SW:              nxt = S_MEMADR;
          OP_RTYPE:                  nxt = S_RTEX;
          OP_BEQ:                    nxt = S_BRANCH;
          OP_BNE:                    if (EN_BNE != 0) nxt = S_BRANCH; else illegal = 1'b1;
          OP_ADDI, OP_ANDI, OP_ORI:  nxt = S_IMMEX;
          OP_J:                      if (EN_JUMP != 0) nxt = S_JUMP; else illegal = 1'b1;
          default:                   illegal = 1'b1;
        endcase
        if (illegal) nxt = S_FETCH;
      end
      S_MEMADR: nxt = (OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_rdy) nxt = S_MEMWB;
      S_MEMWR:  if (mem_rdy) nxt = S_FETCH;
      S_RTEX:   nxt = S_RTWB;
      S_IMMEX:  nxt = S_IMMWB;
      default:  nxt = S_FETCH;  // write-back, branch, jump and unused codes
    endcase
  end

  // State register with the Moore control word registered alongside it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_FETCH;
      mo    <= moore_decode(S_FETCH, OpCode);
    end else begin
      state <= nxt;
      mo    <= moore_decode(nxt, OpCode);
    end
  end

  alu_ctrl_decode #(.ALUCTRL_W(ALUCTRL_W)) u_alu_ctrl (
    .alu_op      (mo.alu_op),
    .funct       (Funct),
    .alu_control (ALUControl)
  );

  // Strobes are suppressed during reset so an abandoned instruction
  // cannot commit anything in the reset cycle.
  assign pc_write  = mo.pc_write | (mo.fetch & mem_rdy);
  assign IRWrite   = ~RST & mo.fetch & mem_rdy;
  assign PCEn      = ~RST & (pc_write | (mo.branch & (Zero ^ mo.branch_ne)));
  assign MemWrite  = ~RST & mo.mem_write;
  assign RegWrite  = ~RST & mo.reg_write;
  assign IllegalOp = ~RST & illegal;

  assign ALUSrcA  = mo.src_a;
  assign ALUSrcB  = mo.src_b;
  assign IorD     = mo.iord;
  assign MemToReg = mo.mem_to_reg;
  assign RegDst   = mo.reg_dst;
  assign PCSrc    = mo.pc_src;
  assign ImmZext  = mo.imm_zext;
  assign StateDbg = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm_v2.sv
// Bench for multicycle_ctrl_fsm_v2: random instruction stream, per-cycle scoreboard.
// Latency: n/a.
// Backpressure: MemReady randomised to exercise wait states.
module tb_multicycle_ctrl_fsm_v2;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                 P_MEMWR = 5, P_RTEX = 6, P_RTWB = 7, P_BRANCH = 8, P_IMMEX = 9,
                 P_IMMWB = 10, P_JUMP = 11;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
                         BNE = 6'b000101, ADDI = 6'b001000, ANDI = 6'b001100,
                         ORI = 6'b001101, JMP = 6'b000010;

  typedef struct packed {
    logic [3:0] st;
    logic       hi;
    logic [2:0] alu;
    logic       srca;
    logic [1:0] srcb;
    logic       iord;
    logic       irw;
    logic       memw;
    logic       m2r;
    logic       regdst;
    logic       regw;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       immz;
    logic       ill;
  } obs_t;

  typedef struct {
    obs_t o;
    obs_t mask;
    bit   dut_b;
  } exp_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST, Zero, MemReady;
  logic [5:0] OpCode, Funct;

  logic [2:0] ctl_a;  logic [3:0] ctl_b;
  logic srca_a, iord_a, irw_a, memw_a, m2r_a, rdst_a, regw_a, pcen_a, immz_a, ill_a;
  logic srca_b, iord_b, irw_b, memw_b, m2r_b, rdst_b, regw_b, pcen_b, immz_b, ill_b;
  logic [1:0] srcb_a, pcsrc_a, srcb_b, pcsrc_b;
  logic [3:0] dbg_a, dbg_b;

  multicycle_ctrl_fsm_v2 dut_a (
    .CLK(CLK), .RST(RST), .OpCode(OpCode), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .ALUControl(ctl_a), .ALUSrcA(srca_a), .ALUSrcB(srcb_a), .IorD(iord_a), .IRWrite(irw_a),
    .MemWrite(memw_a), .MemToReg(m2r_a), .RegDst(rdst_a), .RegWrite(regw_a), .PCSrc(pcsrc_a),
    .PCEn(pcen_a), .ImmZext(immz_a), .IllegalOp(ill_a), .StateDbg(dbg_a)
  );

  multicycle_ctrl_fsm_v2 #(.ALUCTRL_W(4), .EN_BNE(0), .EN_JUMP(0), .EN_MEM_WAIT(0)) dut_b (
    .CLK(CLK), .RST(RST), .OpCode(OpCode), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .ALUControl(ctl_b), .ALUSrcA(srca_b), .ALUSrcB(srcb_b), .IorD(iord_b), .IRWrite(irw_b),
    .MemWrite(memw_b), .MemToReg(m2r_b), .RegDst(rdst_b), .RegWrite(regw_b), .PCSrc(pcsrc_b),
    .PCEn(pcen_b), .ImmZext(immz_b), .IllegalOp(ill_b), .StateDbg(dbg_b)
  );

  obs_t obs_a, obs_b;
  always_comb begin
    obs_a = '0;
    obs_a.st = dbg_a; obs_a.hi = 1'b0; obs_a.alu = ctl_a; obs_a.srca = srca_a;
    obs_a.srcb = srcb_a; obs_a.iord = iord_a; obs_a.irw = irw_a; obs_a.memw = memw_a;
    obs_a.m2r = m2r_a; obs_a.regdst = rdst_a; obs_a.regw = regw_a; obs_a.pcsrc = pcsrc_a;
    obs_a.pcen = pcen_a; obs_a.immz = immz_a; obs_a.ill = ill_a;
  end
  always_comb begin
    obs_b = '0;
    obs_b.st = dbg_b; obs_b.hi = ctl_b[3]; obs_b.alu = ctl_b[2:0]; obs_b.srca = srca_b;
    obs_b.srcb = srcb_b; obs_b.iord = iord_b; obs_b.irw = irw_b; obs_b.memw = memw_b;
    obs_b.m2r = m2r_b; obs_b.regdst = rdst_b; obs_b.regw = regw_b; obs_b.pcsrc = pcsrc_b;
    obs_b.pcen = pcen_b; obs_b.immz = immz_b; obs_b.ill = ill_b;
  end

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic bit legal(logic [5:0] op, bit cfg_b);
    case (op)
      LW, SW, RT, BEQ, ADDI, ANDI, ORI: return 1'b1;
      BNE, JMP:                         return !cfg_b;
      default:                          return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] funct_code(logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs for one cycle, straight from the per-phase output table.
  function automatic exp_t exp_out(int ph, logic [5:0] op, logic [5:0] fn, logic zero,
                                   logic mr, logic rst, bit cfg_b);
    exp_t e; obs_t o; logic mr_e, pcw, br, bne; bit chk;
    o = '0; pcw = 1'b0; br = 1'b0; bne = 1'b0; chk = 1'b0;
    mr_e = cfg_b ? 1'b1 : mr;
    o.st = ph[3:0];
    case (ph)
      P_FETCH:  begin o.srcb = 2'b01; o.alu = 3'b010; o.irw = mr_e; pcw = mr_e; chk = 1'b1; end
      P_DECODE: begin o.srcb = 2'b11; o.alu = 3'b010; o.ill = !legal(op, cfg_b); chk = 1'b1; end
      P_MEMADR: begin o.srca = 1'b1; o.srcb = 2'b10; o.alu = 3'b010; chk = 1'b1; end
      P_MEMRD:  o.iord = 1'b1;
      P_MEMWB:  begin o.m2r = 1'b1; o.regw = 1'b1; end
      P_MEMWR:  begin o.iord = 1'b1; o.memw = 1'b1; end
      P_RTEX:   begin o.srca = 1'b1; o.alu = funct_code(fn); chk = 1'b1; end
      P_RTWB:   begin o.regdst = 1'b1; o.regw = 1'b1; end
      P_BRANCH: begin o.srca = 1'b1; o.alu = 3'b110; o.pcsrc = 2'b01; br = 1'b1;
                      bne = (op == BNE); chk = 1'b1; end
      P_IMMEX:  begin o.srca = 1'b1; o.srcb = 2'b10; chk = 1'b1;
                      o.alu = (op == ANDI) ? 3'b000 : (op == ORI) ? 3'b001 : 3'b010;
                      o.immz = (op == ANDI) || (op == ORI); end
      P_IMMWB:  begin o.regw = 1'b1; o.immz = (op == ANDI) || (op == ORI); end
      P_JUMP:   begin o.pcsrc = 2'b10; pcw = 1'b1; end
      default:  ;
    endcase
    o.pcen = pcw | (br & (zero ^ bne));
    if (rst) begin o.irw = 1'b0; o.pcen = 1'b0; o.regw = 1'b0; o.memw = 1'b0; o.ill = 1'b0; end
    e.mask = '1;
    if (!chk) e.mask.alu = 3'b000;
    e.o = o; e.dut_b = cfg_b;
    return e;
  endfunction

  // Monitor: one scoreboard entry per cycle, compared mid-cycle.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e; obs_t act;
      e = exp_q.pop_front();
      act = e.dut_b ? obs_b : obs_a;
      n_chk++;
      if ((act & e.mask) !== (e.o & e.mask)) begin
        n_fail++;
        $display("FAIL outputs dut=%s phase=%0d actual=%h required=%h (mask %h)",
                 e.dut_b ? "b" : "a", e.o.st, act, e.o, e.mask);
      end
    end
  end

  // Driver and reference model: each instruction is a list of phases; memory
  // phases repeat while MemReady is low; reset abandons the list.
  task automatic run_cfg(input bit cfg_b, input int n_instr);
    int seq[$]; int idx, instr, cyc, ph;
    bit fresh, rst_now; logic mr, zr; logic [5:0] op, fn;
    fresh = 1'b1; instr = 0; cyc = 0; idx = 0; op = '0; fn = '0;
    RST = 1'b1;
    @(posedge CLK);
    while (instr < n_instr && cyc < 4000) begin
      #1;
      if (fresh) begin
        instr++;
        case ($urandom_range(0, 10))
          0: op = LW;   1: op = SW;   2: op = RT;   3: op = BEQ;  4: op = BNE;
          5: op = ADDI; 6: op = ANDI; 7: op = ORI;  8: op = JMP;  9: op = 6'($urandom);
          default: op = 6'b111111;
        endcase
        if (instr == 3) op = LW;
        if (instr == 4) op = BNE;
        if (instr == 5) op = 6'b111111;
        case ($urandom_range(0, 5))
          0: fn = 6'b100000; 1: fn = 6'b100010; 2: fn = 6'b100100;
          3: fn = 6'b100101; 4: fn = 6'b101010; default: fn = 6'($urandom);
        endcase
        seq.delete();
        seq.push_back(P_FETCH); seq.push_back(P_DECODE);
        if (legal(op, cfg_b)) begin
          case (op)
            LW:             begin seq.push_back(P_MEMADR); seq.push_back(P_MEMRD); seq.push_back(P_MEMWB); end
            SW:             begin seq.push_back(P_MEMADR); seq.push_back(P_MEMWR); end
            RT:             begin seq.push_back(P_RTEX); seq.push_back(P_RTWB); end
            BEQ, BNE:       seq.push_back(P_BRANCH);
            ADDI, ANDI, ORI: begin seq.push_back(P_IMMEX); seq.push_back(P_IMMWB); end
            JMP:            seq.push_back(P_JUMP);
            default:        ;
          endcase
        end
        idx = 0; fresh = 1'b0;
      end
      ph = seq[idx];
      rst_now = (cyc < 2) || ($urandom_range(0, 59) == 0) || (instr == 3 && ph == P_MEMWB);
      mr = ($urandom_range(0, 3) != 0);
      zr = 1'($urandom_range(0, 1));
      RST = rst_now; MemReady = mr; Zero = zr; OpCode = op; Funct = fn;
      exp_q.push_back(exp_out(ph, op, fn, zr, mr, rst_now, cfg_b));
      if (rst_now) fresh = 1'b1;
      else if (!((ph == P_FETCH || ph == P_MEMRD || ph == P_MEMWR) && !(mr || cfg_b))) begin
        idx++;
        if (idx >= seq.size()) fresh = 1'b1;
      end
      cyc++;
      @(posedge CLK);
    end
  endtask

  initial begin
    RST = 1'b1; MemReady = 1'b0; Zero = 1'b0; OpCode = '0; Funct = '0;
    run_cfg(1'b0, 150);
    run_cfg(1'b1, 100);
    @(negedge CLK);
    @(negedge CLK);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
